// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) game engine.
package genius_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADD,
      S_APPEND,
      S_SHOW_ON,
      S_SHOW_OFF,
      S_WAIT_IN,
      S_ROUND_OK,
      S_WIN,
      S_LOSE
   } state_t;

   // 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
   // In right-shift form the feedback is taken from bits 0, 2, 3 and 5.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

   // Rounds needed to win: MAX_LEN/8, /4, /2 or MAX_LEN for difficulty 0..3.
   function automatic int target_len(input int max_len, input logic [1:0] diff);
      return max_len >> (3 - int'(diff));
   endfunction

endpackage

// File: rtl/genius_seq_mem.sv
// Colour sequence storage: synchronous write, asynchronous read.
module genius_seq_mem #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/genius_engine.sv
// Genius (Simon) game engine: sequence generation, LED playback, response
// checking and scoring for NUM_COLORS colours.
// Optional build macro GENIUS_TIMEOUT_EN adds an input timeout in WAIT_IN.
module genius_engine
   import genius_pkg::*;
#(
   parameter  int NUM_COLORS     = 4,
   parameter  int MAX_LEN        = 16,
   parameter  int SHOW_CYCLES    = 8,
   parameter  int GAP_CYCLES     = 4,
   parameter  int TIMEOUT_CYCLES = 64,
   localparam int CW             = $clog2(NUM_COLORS),
   localparam int SW             = $clog2(MAX_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [1:0]            difficulty,
   input  logic [1:0]            speed,
   input  logic                  player_valid,
   input  logic [CW-1:0]         player_color,
   output logic [NUM_COLORS-1:0] leds,
   output logic [SW-1:0]         score,
   output logic                  busy,
   output logic                  win,
   output logic                  lose
);

   localparam int IW   = $clog2(MAX_LEN);
   localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   if (!(NUM_COLORS == 2 || NUM_COLORS == 4 || NUM_COLORS == 8) ||
       (MAX_LEN % 8) != 0 || MAX_LEN > 64 || MAX_LEN < 8 ||
       SHOW_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("genius_engine: illegal parameter set");
   end

   state_t          state, nstate;
   logic [15:0]     lfsr;
   logic            mode_q;
   logic [1:0]      diff_q, speed_q;
   logic [SW-1:0]   len, target;
   logic [IW-1:0]   idx, match_idx, rd_idx;
   logic [TW-1:0]   tcnt, on_raw, off_raw, on_t, off_t;
   logic [CW-1:0]   rd_col, wr_col;
   logic            mem_we, idle_like, idx_last, match_last;
   logic            show_end, gap_end, hit, tmo_hit;

   assign idle_like  = (state == S_IDLE) || (state == S_WIN) || (state == S_LOSE);
   assign target     = SW'(target_len(MAX_LEN, diff_q));

   // Speed divides both phases; a phase never shrinks below one cycle.
   assign on_raw     = TW'(SHOW_CYCLES) >> speed_q;
   assign off_raw    = TW'(GAP_CYCLES) >> speed_q;
   assign on_t       = (on_raw == '0) ? TW'(1) : on_raw;
   assign off_t      = (off_raw == '0) ? TW'(1) : off_raw;
   assign show_end   = (tcnt == on_t - TW'(1));
   assign gap_end    = (tcnt == off_t - TW'(1));

   // One read port serves playback and checking; they never overlap in time.
   assign rd_idx     = (state == S_WAIT_IN) ? match_idx : idx;
   assign idx_last   = (SW'(idx) == len - SW'(1));
   assign match_last = (SW'(match_idx) == len - SW'(1));
   assign hit        = (player_color == rd_col);

   genius_seq_mem #(
      .DEPTH (MAX_LEN),
      .WIDTH (CW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (IW'(len)),
      .wdata (wr_col),
      .raddr (rd_idx),
      .rdata (rd_col)
   );

`ifdef GENIUS_TIMEOUT_EN
   localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
   logic [OW-1:0] tmo_cnt;

   assign tmo_hit = (tmo_cnt == OW'(TIMEOUT_CYCLES - 1));

   // Idle timer for WAIT_IN; restarts on entry and on every press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                  tmo_cnt <= '0;
      else if (state != S_WAIT_IN || player_valid) tmo_cnt <= '0;
      else                                       tmo_cnt <= tmo_cnt + OW'(1);
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Free-running random source; the seed is non-zero so it never locks up.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr <= LFSR_SEED;
      else      lfsr <= lfsr_step(lfsr);
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= nstate;
   end

   // Next-state and memory write control.
   always_comb begin
      nstate = state;
      mem_we = 1'b0;
      wr_col = lfsr[CW-1:0];
      case (state)
         S_IDLE, S_WIN, S_LOSE: if (start) nstate = mode ? S_APPEND : S_ADD;
         S_ADD: begin
            mem_we = 1'b1;
            nstate = S_SHOW_ON;
         end
         S_APPEND: if (player_valid) begin
            mem_we = 1'b1;
            wr_col = player_color;
            nstate = S_SHOW_ON;
         end
         S_SHOW_ON:  if (show_end) nstate = S_SHOW_OFF;
         S_SHOW_OFF: if (gap_end)  nstate = idx_last ? S_WAIT_IN : S_SHOW_ON;
         S_WAIT_IN: begin
            if (player_valid) begin
               if (!hit)            nstate = S_LOSE;
               else if (match_last) nstate = S_ROUND_OK;
            end else if (tmo_hit) begin
               nstate = S_LOSE;
            end
         end
         S_ROUND_OK: begin
            if (score + SW'(1) == target) nstate = S_WIN;
            else                          nstate = mode_q ? S_APPEND : S_ADD;
         end
         default: nstate = S_IDLE;
      endcase
   end

   // Game datapath: configuration latch, length, indices, phase timer, score.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q    <= 1'b0;
         diff_q    <= '0;
         speed_q   <= '0;
         len       <= '0;
         score     <= '0;
         idx       <= '0;
         match_idx <= '0;
         tcnt      <= '0;
      end else begin
         if (idle_like && start) begin
            mode_q  <= mode;
            diff_q  <= difficulty;
            speed_q <= speed;
            len     <= '0;
            score   <= '0;
         end
         if (mem_we) begin
            len <= len + SW'(1);
            idx <= '0;
         end else if (state == S_SHOW_OFF && gap_end && !idx_last) begin
            idx <= idx + IW'(1);
         end
         if (state != S_WAIT_IN)                      match_idx <= '0;
         else if (player_valid && nstate == S_WAIT_IN) match_idx <= match_idx + IW'(1);
         if (nstate != state)                               tcnt <= '0;
         else if (state == S_SHOW_ON || state == S_SHOW_OFF) tcnt <= tcnt + TW'(1);
         if (state == S_ROUND_OK) score <= score + SW'(1);
      end
   end

   // Playback LEDs: one-hot of the current item, all lit on a win.
   for (genvar c = 0; c < NUM_COLORS; c++) begin : g_led
      assign leds[c] = ((state == S_SHOW_ON) && (rd_col == CW'(c))) || (state == S_WIN);
   end

   assign busy = !idle_like;
   assign win  = (state == S_WIN);
   assign lose = (state == S_LOSE);

endmodule

// File: tb/tb_genius_engine.sv
// Bench for genius_engine: a sequence-level game model drives expectations,
// one negedge process compares every cycle, and literal checks pin the model.
module tb_genius_engine;

   localparam int NC  = 4;
   localparam int ML  = 16;
   localparam int SC  = 8;
   localparam int GC  = 4;
   localparam int TMO = 10;
   localparam int CW  = 2;
   localparam int SW  = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [1:0]    difficulty = '0;
   logic [1:0]    speed = '0;
   logic          player_valid = 1'b0;
   logic [CW-1:0] player_color = '0;
   logic [NC-1:0] leds;
   logic [SW-1:0] score;
   logic          busy, win, lose;

   always #5 clk = ~clk;

   genius_engine #(
      .NUM_COLORS     (NC),
      .MAX_LEN        (ML),
      .SHOW_CYCLES    (SC),
      .GAP_CYCLES     (GC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mode         (mode),
      .difficulty   (difficulty),
      .speed        (speed),
      .player_valid (player_valid),
      .player_color (player_color),
      .leds         (leds),
      .score        (score),
      .busy         (busy),
      .win          (win),
      .lose         (lose)
   );

   int            n_vec = 0;
   int            n_err = 0;
   bit            chk_on = 1'b0;
   logic [NC-1:0] exp_leds = '0;
   int            exp_score = 0;
   bit            exp_busy = 1'b0, exp_win = 1'b0, exp_lose = 1'b0;

   // Model state: the game as a colour list plus a few numbers.
   logic [15:0]   m_lfsr = 16'hACE1;
   int            seq[$];
   int            obs_first[$];
   int            m_score, m_target, m_mode, on_t, off_t, obs_on, obs_off;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
      end
   endtask

   // Polynomial x^16+x^14+x^13+x^11+1, shifting towards bit 0.
   function automatic logic [15:0] m_step(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         check("leds",  32'(leds),  32'(exp_leds));
         check("score", 32'(score), 32'(exp_score));
         check("busy",  32'(busy),  32'(exp_busy));
         check("win",   32'(win),   32'(exp_win));
         check("lose",  32'(lose),  32'(exp_lose));
      end
   end

   task automatic tick();
      @(posedge clk);
      m_lfsr = rst ? m_step(m_lfsr) : 16'hACE1;
      #1;
      start        = 1'b0;
      player_valid = 1'b0;
   endtask

   task automatic start_game(input int m, input int d, input int s);
      start      = 1'b1;
      mode       = m[0];
      difficulty = d[1:0];
      speed      = s[1:0];
      tick();
      seq.delete();
      m_score  = 0;
      m_mode   = m;
      m_target = ML >> (3 - d);
      on_t     = (SC >> s) < 1 ? 1 : (SC >> s);
      off_t    = (GC >> s) < 1 ? 1 : (GC >> s);
      exp_busy = 1'b1; exp_win = 1'b0; exp_lose = 1'b0;
      exp_leds = '0;   exp_score = 0;
      if (m == 0) seq.push_back(int'(m_lfsr[CW-1:0]));
   endtask

   // Play every item; a stray wrong press during the first item must be ignored.
   task automatic play();
      for (int i = 0; i < seq.size(); i++) begin
         obs_on  = 0;
         obs_off = 0;
         for (int k = 0; k < on_t; k++) begin
            if (i == 0 && k == 1) begin
               player_valid = 1'b1;
               player_color = CW'(seq[0] + 1);
            end
            tick();
            exp_leds = NC'(1) << seq[i];
            if (k == 0) obs_first.push_back(int'(leds));
            if (leds != '0) obs_on++;
         end
         for (int k = 0; k < off_t; k++) begin
            tick();
            exp_leds = '0;
            if (leds == '0) obs_off++;
         end
      end
   endtask

   task automatic enter_wait();
      tick();
      exp_leds = '0;
   endtask

   // Replay the sequence, substituting wrong_col at position wrong_at (-1: none).
   task automatic replay_round(input int wrong_at, input int wrong_col);
      for (int mi = 0; mi < seq.size(); mi++) begin
         int c;
         c = (mi == wrong_at) ? wrong_col : seq[mi];
         player_valid = 1'b1;
         player_color = CW'(c);
         tick();
         if (c != seq[mi]) begin
            exp_busy = 1'b0;
            exp_lose = 1'b1;
            return;
         end
         if (mi == seq.size() - 1) begin
            tick();
            m_score++;
            exp_score = m_score;
            if (m_score == m_target) begin
               exp_busy = 1'b0;
               exp_win  = 1'b1;
               exp_leds = '1;
            end else if (m_mode == 0) begin
               seq.push_back(int'(m_lfsr[CW-1:0]));
            end
            return;
         end
         tick();
      end
   endtask

   initial begin
      // Power-on reset.
      repeat (3) tick();
      chk_on = 1'b1;
      tick();
      rst = 1'b1;
      repeat (2) tick();

      // Reset asserted in the middle of SHOW_ON.
      start_game(0, 0, 0);
      tick();
      exp_leds = NC'(1) << seq[0];
      #1 rst = 1'b0;
      m_lfsr = 16'hACE1;
      #1;
      check("rst_leds", 32'(leds), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_score", 32'(score), 32'd0);
      check("rst_win_lose", 32'({win, lose}), 32'd0);
      exp_leds = '0; exp_busy = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      repeat (2) tick();

      // Classic game, target 2, two correct rounds.
      start_game(0, 0, 0);
      play();
      enter_wait();
      replay_round(-1, 0);
      check("classic_score_r1", 32'(score), 32'd1);
      play();
      enter_wait();
      replay_round(-1, 0);
      check("classic_win", 32'(win), 32'd1);
      check("classic_win_leds", 32'(leds), 32'hF);
      check("classic_score_r2", 32'(score), 32'd2);
      repeat (3) tick();

      // Wrong colour at the first position of round 1.
      start_game(0, 0, 0);
      play();
      enter_wait();
      replay_round(0, (seq[0] + 1) % NC);
      check("lose_flag", 32'(lose), 32'd1);
      check("lose_score", 32'(score), 32'd0);
      check("lose_busy", 32'(busy), 32'd0);
      repeat (2) tick();

      // Speed 2: two cycles on, one off; lose at match index 1 of round 2.
      start_game(0, 1, 2);
      play();
      check("speed2_on_cycles", 32'(obs_on), 32'd2);
      check("speed2_off_cycles", 32'(obs_off), 32'd1);
      enter_wait();
      replay_round(-1, 0);
      play();
      enter_wait();
      replay_round(1, (seq[1] + 2) % NC);
      check("speed2_lose_score", 32'(score), 32'd1);
      check("speed2_lose_flag", 32'(lose), 32'd1);
      repeat (2) tick();

      // Player-append mode: append 3, replay, append 1, replay to win.
      start_game(1, 0, 0);
      repeat (2) tick();
      player_valid = 1'b1; player_color = 2'd3; seq.push_back(3);
      play();
      enter_wait();
      replay_round(-1, 0);
      obs_first.delete();
      tick();
      player_valid = 1'b1; player_color = 2'd1; seq.push_back(1);
      play();
      check("mode1_item0", 32'(obs_first[0]), 32'b1000);
      check("mode1_item1", 32'(obs_first[1]), 32'b0010);
      enter_wait();
      replay_round(-1, 0);
      check("mode1_win", 32'(win), 32'd1);
      repeat (2) tick();

      // No input in WAIT_IN; a start pulse there must be ignored.
      start_game(0, 0, 0);
      play();
      enter_wait();
`ifdef GENIUS_TIMEOUT_EN
      repeat (TMO - 1) tick();
      tick();
      exp_busy = 1'b0;
      exp_lose = 1'b1;
      check("timeout_lose", 32'(lose), 32'd1);
`else
      repeat (50) tick();
      start = 1'b1;
      tick();
      repeat (49) tick();
      check("no_timeout_busy", 32'(busy), 32'd1);
`endif
      tick();
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/genius_engine.md
# genius_engine

Parametrised Genius (Simon) game engine: owns the colour sequence, plays it back on one-hot LEDs, checks player responses, and keeps score. It generalises the current two-bit, fixed-depth game top to N colours, configurable depth, speed-scaled playback and two game modes. The score output feeds the existing 7-segment score driver.

## Interface
- NUM_COLORS, 4: colour count; legal values 2, 4, 8. CW = $clog2(NUM_COLORS).
- MAX_LEN, 16: sequence memory depth; multiple of 8, at most 64. SW = $clog2(MAX_LEN+1).
- SHOW_CYCLES, 8: LED on-time per item at speed 0.
- GAP_CYCLES, 4: LED off-time between items at speed 0.
- TIMEOUT_CYCLES, 64: input timeout; used only when GENIUS_TIMEOUT_EN is defined.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a game from IDLE, WIN or LOSE.
- mode  in  1  0 = classic (engine appends random colours), 1 = player-append; sampled on start.
- difficulty  in  2  target length = MAX_LEN >> (3 - difficulty); sampled on start.
- speed  in  2  timing divisor shift; sampled on start.
- player_valid  in  1  one-cycle pulse qualifying player_color.
- player_color  in  CW  colour pressed.
- leds  out  NUM_COLORS  one-hot playback, or all-ones on WIN.
- score  out  SW  rounds completed.
- busy  out  1  high in every state except IDLE, WIN and LOSE.
- win  out  1  high while in WIN.
- lose  out  1  high while in LOSE.

## Operation
- States: IDLE, ADD, APPEND, SHOW_ON, SHOW_OFF, WAIT_IN, ROUND_OK, WIN, LOSE.
- Reset: state IDLE, leds 0, score 0, busy 0, win 0, lose 0, len 0, LFSR 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Advances every cycle. Never zero. Random colour = lfsr[CW-1:0].
- start in IDLE/WIN/LOSE: latch mode, difficulty and speed; clear len and score. Go to ADD if mode=0, APPEND if mode=1. start in any other state is ignored.
- ADD: write the random colour at index len, len++, go to SHOW_ON with item 0.
- APPEND: wait for player_valid, write player_color at index len, len++, go to SHOW_ON.
- SHOW_ON: leds = one-hot of mem[idx] for on_t = max(1, SHOW_CYCLES >> speed) cycles, then go to SHOW_OFF.
- SHOW_OFF: leds = 0 for off_t = max(1, GAP_CYCLES >> speed) cycles. Then idx++ and SHOW_ON, or, if idx == len-1, WAIT_IN with match_idx = 0.
- WAIT_IN, on player_valid: compare player_color with mem[match_idx].
  - Mismatch: go to LOSE.
  - Match with match_idx == len-1: go to ROUND_OK.
  - Otherwise: match_idx++.
- player_valid is ignored outside WAIT_IN and APPEND.
- ROUND_OK (one cycle): score++. If the new score == target, go to WIN. Otherwise go to ADD (mode 0) or APPEND (mode 1).
- WIN/LOSE: hold until start or reset; score is held.
- Reset asserted mid-game: immediate return to the reset values above; memory contents are don't-care.

## Timing
- start at edge t: busy=1 from t+1. In mode 0, ADD occupies t+1 and leds go valid at t+2.
- Each played item occupies exactly on_t + off_t cycles. A round of length L plays for L·(on_t+off_t) cycles after ADD.
- A comparison is resolved in the cycle player_valid is sampled. State and score update at the next edge; the ROUND_OK score increment is visible one cycle after the final correct input.
- Memory: synchronous write, combinational read; write-then-read of the same index is not needed within one cycle.
- score never exceeds target ≤ MAX_LEN, so len never overflows the memory.

## Configuration
- GENIUS_TIMEOUT_EN defined: a counter clears on entry to WAIT_IN and on every accepted input. If it reaches TIMEOUT_CYCLES with no player_valid, go to LOSE.
- Not defined: WAIT_IN waits indefinitely, no counter logic is present, and TIMEOUT_CYCLES is unused.

## Structure
- genius_pkg holds the state enum typedef, the LFSR seed and taps constants, and the target-length function.
- One sub-module, genius_seq_mem: MAX_LEN × CW storage with a write port and an asynchronous read port. The engine multiplexes the read index between idx (playback) and match_idx (checking).

## Test plan
- Reset: hold rst=0 mid-SHOW_ON → all outputs 0 and state IDLE within the reset-assert cycle.
- Classic win with NUM_COLORS=4, MAX_LEN=16, difficulty=0 (target 2), speed=0: replay the observed LEDs correctly twice → score 1 then 2, win=1, leds=4'b1111.
- Wrong colour at match_idx 0 in round 1 → lose=1, score 0, busy=0 on the next cycle.
- Speed=2 with SHOW_CYCLES=8, GAP_CYCLES=4: LEDs on for 2 cycles and off for 1 cycle per item.
- Mode 1: append 3, replay 3, append 1 → round 2 plays one-hot 4'b1000 then 4'b0010.
- GENIUS_TIMEOUT_EN with TIMEOUT_CYCLES=10: no input for 10 cycles in WAIT_IN → lose=1. Without the macro, the same stimulus leaves busy=1 after 100 cycles.
